memory_bank: RTL and testbench

//  Parametrised successor to the fixed 32-tank store. It models NUM_TANKS

---
 rtl/memory_bank_pkg.sv | 20 ++
 rtl/memory_bank_if.sv | 26 ++
 rtl/memory_bank_delay_tank.sv | 34 +++
 rtl/memory_bank.sv | 156 +++++++++++++++
 tb/tb_memory_bank.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_bank_pkg.sv
// Shared definitions for the circulating tank store: FSM encoding and
// elaboration-time width helpers.
package memory_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tank_len(input int words, input int word_bits);
        return words * word_bits;
    endfunction

endpackage

// File: rtl/memory_bank_if.sv
// Single-request handshake between the control unit and the tank store.
interface memory_bank_if #(
    parameter int TANK_W    = 5,
    parameter int WORD_W    = 4,
    parameter int WORD_BITS = 36
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [TANK_W-1:0]    req_tank;
    logic [WORD_W-1:0]    req_word;
    logic [WORD_BITS-1:0] req_wdata;
    logic                 rsp_valid;
    logic                 rsp_err;
    logic [WORD_BITS-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_tank, req_word, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_tank, req_word, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/memory_bank_delay_tank.sv
// One circulating delay-line tank: LEN-bit shift register, LSB leaves first.
module delay_tank #(
    parameter int LEN = 576
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           wr_en,
    input  logic           wr_bit,
    output logic           out_bit,
    output logic [LEN-1:0] mon
);
    logic [LEN-1:0] line_reg;
    logic           in_bit;

    // Clear beats write; otherwise the leaving bit recirculates.
    always_comb begin
        in_bit = line_reg[0];
        if (clr)
            in_bit = 1'b0;
        else if (wr_en)
            in_bit = wr_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            line_reg <= '0;
        else
            line_reg <= {in_bit, line_reg[LEN-1:1]};
    end

    assign out_bit = line_reg[0];
    assign mon     = line_reg;
endmodule

// File: rtl/memory_bank.sv
// NUM_TANKS circulating tanks sharing one bit/word position counter, with a
// handshake port that word-aligns, reads and optionally writes one word.
module memory_bank
    import memory_bank_pkg::*;
#(
    parameter  int NUM_TANKS = 32,
    parameter  int WORDS     = 16,
    parameter  int WORD_BITS = 36,
    parameter  int TANK_W    = 5,
    parameter  int WORD_W    = 4,
    localparam int L         = tank_len(WORDS, WORD_BITS),
    localparam int BIT_W     = idx_bits(WORD_BITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    memory_bank_if.slave         bus,
    input  logic [NUM_TANKS-1:0] tank_clr,
    input  logic [TANK_W-1:0]    mon_sel,
    output logic [L-1:0]         mon_data,
    output logic [BIT_W-1:0]     bit_pos,
    output logic [WORD_W-1:0]    word_pos,
    output logic                 word_sync
);
    localparam int TI_W  = idx_bits(NUM_TANKS);
    localparam int ROT_W = idx_bits(2 * L);
    localparam logic [TANK_W:0] TANK_LIM = (TANK_W + 1)'(NUM_TANKS);
    localparam logic [WORD_W:0] WORD_LIM = (WORD_W + 1)'(WORDS);

    logic [BIT_W-1:0]     bit_pos_reg;
    logic [WORD_W-1:0]    word_pos_reg;
    state_t               state_reg;
    logic                 lat_write_reg;
    logic [TANK_W-1:0]    lat_tank_reg;
    logic [WORD_W-1:0]    lat_word_reg;
    logic [WORD_BITS-1:0] lat_wdata_reg;
    logic [WORD_BITS-1:0] rdata_reg;
    logic                 req_ready_reg;
    logic                 rsp_valid_reg;
    logic                 rsp_err_reg;
    logic [WORD_BITS-1:0] rsp_rdata_reg;

    logic [NUM_TANKS-1:0] out_bits;
    logic [L-1:0]         tank_mon [NUM_TANKS];
    logic                 hit;
    logic                 xfer_bit;
    logic                 sel_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_pos_reg  <= '0;
            word_pos_reg <= '0;
        end else if (bit_pos_reg == BIT_W'(WORD_BITS - 1)) begin
            bit_pos_reg  <= '0;
            word_pos_reg <= (word_pos_reg == WORD_W'(WORDS - 1)) ? '0
                          : word_pos_reg + WORD_W'(1);
        end else begin
            bit_pos_reg  <= bit_pos_reg + BIT_W'(1);
        end
    end

    assign hit      = (word_pos_reg == lat_word_reg) && (bit_pos_reg == '0);
    assign xfer_bit = ((state_reg == ST_WAIT) && hit)
                   || ((state_reg == ST_XFER) && (bit_pos_reg != '0));
    assign sel_out  = out_bits[lat_tank_reg[TI_W-1:0]];

    for (genvar gi = 0; gi < NUM_TANKS; gi++) begin : g_tank
        delay_tank #(.LEN(L)) u_tank (
            .clk     (clk),
            .rst     (rst),
            .clr     (tank_clr[gi]),
            .wr_en   (xfer_bit && lat_write_reg && (lat_tank_reg == TANK_W'(gi))),
            .wr_bit  (lat_wdata_reg[bit_pos_reg]),
            .out_bit (out_bits[gi]),
            .mon     (tank_mon[gi])
        );
    end

    // XFER leaves on the word boundary after the last bit, so the response
    // appears one cycle after the final transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            lat_write_reg <= 1'b0;
            lat_tank_reg  <= '0;
            lat_word_reg  <= '0;
            lat_wdata_reg <= '0;
            rdata_reg     <= '0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            if (xfer_bit)
                rdata_reg[bit_pos_reg] <= sel_out;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_reg) begin
                        lat_write_reg <= bus.req_write;
                        lat_tank_reg  <= bus.req_tank;
                        lat_word_reg  <= bus.req_word;
                        lat_wdata_reg <= bus.req_wdata;
                        req_ready_reg <= 1'b0;
                        if (({1'b0, bus.req_tank} >= TANK_LIM)
                                || ({1'b0, bus.req_word} >= WORD_LIM)) begin
                            state_reg     <= ST_DONE;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_rdata_reg <= '0;
                        end else begin
                            state_reg <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (hit)
                        state_reg <= ST_XFER;
                end
                ST_XFER: begin
                    if (bit_pos_reg == '0) begin
                        state_reg     <= ST_DONE;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b0;
                        rsp_rdata_reg <= rdata_reg;
                    end
                end
                ST_DONE: begin
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b1;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Rotate the selected shift register back into word order:
    // physical bit j currently holds logical bit (pos + j) mod L.
    logic [L-1:0]     mon_raw;
    logic [2*L-1:0]   mon_dbl;
    logic [ROT_W-1:0] cur_pos;
    logic [ROT_W-1:0] rot_off;

    assign mon_raw  = tank_mon[mon_sel[TI_W-1:0]];
    assign mon_dbl  = {mon_raw, mon_raw};
    assign cur_pos  = ROT_W'(word_pos_reg) * ROT_W'(WORD_BITS) + ROT_W'(bit_pos_reg);
    assign rot_off  = ROT_W'(L) - cur_pos;
    assign mon_data = mon_dbl[rot_off +: L];

    assign bit_pos       = bit_pos_reg;
    assign word_pos      = word_pos_reg;
    assign word_sync     = (bit_pos_reg == '0);
    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
endmodule

// File: tb/tb_memory_bank.sv
// Directed bench for memory_bank: word-level shadow model plus a response
// scoreboard queue; index ports widened so out-of-range indices are reachable.
module tb_memory_bank;
    localparam int NT = 32;
    localparam int NW = 16;
    localparam int WB = 36;
    localparam int TW = 6;
    localparam int WW = 5;
    localparam int L  = NW * WB;
    localparam int BW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_bank_if #(.TANK_W(TW), .WORD_W(WW), .WORD_BITS(WB)) bus ();

    logic [NT-1:0] tank_clr;
    logic [TW-1:0] mon_sel;
    logic [L-1:0]  mon_data;
    logic [BW-1:0] bit_pos;
    logic [WW-1:0] word_pos;
    logic          word_sync;

    memory_bank #(
        .NUM_TANKS(NT), .WORDS(NW), .WORD_BITS(WB), .TANK_W(TW), .WORD_W(WW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .tank_clr  (tank_clr),
        .mon_sel   (mon_sel),
        .mon_data  (mon_data),
        .bit_pos   (bit_pos),
        .word_pos  (word_pos),
        .word_sync (word_sync)
    );

    typedef struct {
        logic [WB-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          sb [$];
    logic [WB-1:0] mdl [NT][NW];
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [L-1:0] mdl_image(input int t);
        logic [L-1:0] v;
        v = '0;
        for (int w = 0; w < NW; w++)
            v[w*WB +: WB] = mdl[t][w];
        return v;
    endfunction

    task automatic check_mon(input string tag, input int t);
        mon_sel = TW'(t);
        #1;
        check(tag, mon_data, mdl_image(t));
    endtask

    // Called at a falling edge; returns at the falling edge where (w,b) is current.
    task automatic wait_pos(input int w, input int b);
        int n;
        n = 0;
        while (!(int'(word_pos) == w && int'(bit_pos) == b) && n < 2 * L) begin
            @(negedge clk);
            n++;
        end
        check("wait_pos reached", n < 2 * L, 1'b1);
    endtask

    task automatic do_req(input string tag, input bit wr, input int t, input int w,
                          input logic [WB-1:0] wd, output int lat);
        exp_t e;
        check({tag, " req_ready"}, bus.req_ready, 1'b1);
        e.err   = (t >= NT) || (w >= NW);
        e.rdata = '0;
        if (!e.err) begin
            e.rdata = mdl[t][w];
            if (wr)
                mdl[t][w] = tank_clr[t] ? '0 : wd;
        end
        sb.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_tank  = TW'(t);
        bus.req_word  = WW'(w);
        bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " rsp_valid"}, bus.rsp_valid, 1'b1);
        if (bus.rsp_valid) begin
            e = sb.pop_front();
            check({tag, " rsp_err"}, bus.rsp_err, e.err);
            if (!e.err)
                check({tag, " rsp_rdata"}, bus.rsp_rdata, e.rdata);
            @(negedge clk);
            check({tag, " one-cycle strobe"}, bus.rsp_valid, 1'b0);
        end
        $display("req %s wr=%0d tank=%0d word=%0d latency=%0d rdata=%h err=%0d",
                 tag, wr, t, w, lat, bus.rsp_rdata, bus.rsp_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_tank  = '0;
        bus.req_word  = '0;
        bus.req_wdata = '0;
        tank_clr      = '0;
        mon_sel       = '0;
        for (int t = 0; t < NT; t++)
            for (int w = 0; w < NW; w++)
                mdl[t][w] = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst req_ready", bus.req_ready, 1'b1);
        check("rst rsp_valid", bus.rsp_valid, 1'b0);
        check("rst rsp_err", bus.rsp_err, 1'b0);
        check("rst rsp_rdata", bus.rsp_rdata, '0);
        check("rst word_pos", word_pos, '0);
        rst = 1'b0;

        // Idle circulation: counters, word_sync, empty tanks
        for (int k = 0; k < 72; k++) begin
            mon_sel = TW'(k % NT);
            #1;
            check("idle mon_data", mon_data, '0);
            check("idle bit_pos", bit_pos, k % WB);
            check("idle word_sync", word_sync, (k % WB) == 0);
            if (k == 36)
                check("word_pos at cycle 36", word_pos, 1);
            @(negedge clk);
        end

        // Write then read back tank 3 word 5
        do_req("wr t3w5", 1'b1, 3, 5, 36'h9_ABCD_1234, lat);
        do_req("rd t3w5", 1'b0, 3, 5, '0, lat);
        check_mon("mon t3 image", 3);
        check("mon t3 word5", mon_data[5*WB +: WB], 36'h9_ABCD_1234);
        repeat (17) @(negedge clk);
        check_mon("mon t3 image rotated", 3);

        // Latency bounds
        wait_pos(4, 35);
        do_req("lat min", 1'b0, 3, 5, '0, lat);
        check("latency min", lat, WB + 2);
        wait_pos(5, 0);
        do_req("lat max", 1'b0, 3, 5, '0, lat);
        check("latency max", lat, L + WB + 1);

        // Out-of-range indices
        do_req("oor tank", 1'b1, 32, 5, 36'hF_FFFF_FFFF, lat);
        check("oor tank latency", lat, 1);
        do_req("oor word", 1'b1, 3, 16, 36'hF_FFFF_FFFF, lat);
        check("oor word latency", lat, 1);
        check_mon("oor t3 untouched", 3);
        check_mon("oor t0 untouched", 0);

        // Neighbour data, fill tank 7, then clear with a write in flight
        do_req("wr t6w0", 1'b1, 6, 0, 36'h1_2345_6789, lat);
        do_req("wr t6w15", 1'b1, 6, 15, 36'h8_7654_3210, lat);
        for (int w = 0; w < NW; w++)
            do_req("fill t7", 1'b1, 7, w, 36'hF_FFFF_FFFF, lat);
        check_mon("mon t7 ones", 7);
        tank_clr[7] = 1'b1;
        do_req("wr during clr", 1'b1, 7, 3, 36'h5_5555_AAAA, lat);
        repeat (L) @(negedge clk);
        tank_clr[7] = 1'b0;
        for (int w = 0; w < NW; w++)
            mdl[7][w] = '0;
        check_mon("mon t7 cleared", 7);
        check_mon("mon t6 unchanged", 6);
        do_req("rd t7w3", 1'b0, 7, 3, '0, lat);
        do_req("rd t6w15", 1'b0, 6, 15, '0, lat);

        // Reset during XFER abandons the request
        mon_sel = TW'(3);
        wait_pos(15, 35);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_tank  = TW'(3);
        bus.req_word  = WW'(0);
        bus.req_wdata = 36'hC_0FFE_E123;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid rst rsp_valid", bus.rsp_valid, 1'b0);
        check("mid rst req_ready", bus.req_ready, 1'b1);
        check("mid rst bit_pos", bit_pos, '0);
        check("mid rst mon t3", mon_data, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < NT; t++)
            for (int w = 0; w < NW; w++)
                mdl[t][w] = '0;
        seen = 0;
        for (int k = 0; k < 45; k++) begin
            if (bus.rsp_valid)
                seen++;
            @(negedge clk);
        end
        check("no rsp after rst", seen, 0);
        do_req("post rst rd t3w5", 1'b0, 3, 5, '0, lat);
        do_req("post rst wr t3w1", 1'b1, 3, 1, 36'h0_DEAD_BEEF, lat);
        do_req("post rst rd t3w1", 1'b0, 3, 1, '0, lat);
        check("scoreboard drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
